// File: rtl/mem_responder_pkg.sv
// Shared types and default geometry for the wait-state memory responder.
package mem_pkg;

  localparam int DEF_ADDR_W      = 8;
  localparam int DEF_DATA_W      = 32;
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int CTR_W           = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Cache-controller-to-memory handshake bundle; the controller is master.
interface mem_responder_if
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);

  logic              MStrobe;
  logic              MRW;
  logic [ADDR_W-1:0] MAddr;
  logic [DATA_W-1:0] MDataIn;
  logic [DATA_W-1:0] MDataOut;
  logic              MReady;
  logic              Busy;
  logic              StrobeErr;

  modport master (
    output MStrobe, MRW, MAddr, MDataIn,
    input  MDataOut, MReady, Busy, StrobeErr
  );

  modport slave (
    input  MStrobe, MRW, MAddr, MDataIn,
    output MDataOut, MReady, Busy, StrobeErr
  );

endinterface

// File: rtl/mem_responder_wait_ctr.sv
// 8-bit wait-state down-counter: load wins over decrement, holds at zero.
module responder_wait_ctr
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             en,
  input  logic [CTR_W-1:0] load_val,
  output logic             zero
);

  logic [CTR_W-1:0] count;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks run in.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// Single-port memory behind a fixed-latency strobe/ready handshake.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic          clk,
  input  logic          reset,
  mem_responder_if.slave bus
);

  localparam logic [CTR_W-1:0] LOAD_VAL = CTR_W'(WAIT_CYCLES - 1);

  state_t            state, state_next;
  logic              accept;
  logic              ctr_zero;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_data;
  logic              lat_rw;
  logic [DATA_W-1:0] data_out;
  logic              strobe_err;
  logic [DATA_W-1:0] mem [2**ADDR_W];

  responder_wait_ctr u_wait_ctr (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .en       (state == WAIT),
    .load_val (LOAD_VAL),
    .zero     (ctr_zero)
  );

  // NOTE: defaults first so every path assigns every output and no latch
  // is inferred; the default arm also recovers the unused encoding.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.MStrobe) begin
          state_next = WAIT;
          accept     = 1'b1;
        end
      end
      WAIT:    if (ctr_zero) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat_addr   <= '0;
      lat_data   <= '0;
      lat_rw     <= 1'b0;
      data_out   <= '0;
      strobe_err <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        lat_addr <= bus.MAddr;
        lat_data <= bus.MDataIn;
        lat_rw   <= bus.MRW;
      end
      // Read data is captured on the edge entering RESP so it is valid there.
      if ((state == WAIT) && ctr_zero && !lat_rw) begin
        data_out <= mem[lat_addr];
      end
      if (bus.MStrobe && (state != IDLE)) begin
        strobe_err <= 1'b1;
      end
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; only the
  // commit is gated by reset, which aborts a write still in RESP.
  always_ff @(posedge clk) begin
    if (!reset && (state == RESP) && lat_rw) begin
      mem[lat_addr] <= lat_data;
    end
  end

  assign bus.MDataOut  = data_out;
  assign bus.MReady    = (state == RESP);
  assign bus.Busy      = (state != IDLE);
  assign bus.StrobeErr = strobe_err;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: one responder with 4 wait states, one with 1 wait state.
module tb_mem_responder;

  logic        clk;
  logic        reset;
  logic        sel;
  logic        strobe;
  logic        rw;
  logic [7:0]  addr;
  logic [31:0] wdata;

  int checks   = 0;
  int failures = 0;
  int rdy_cnt;
  int first_rdy;
  int cyc;
  int lat;
  logic [31:0] rd;
  logic [31:0] mon_data;

  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus_a ();
  mem_responder_if #(.ADDR_W(8), .DATA_W(32)) bus_b ();

  assign bus_a.MStrobe = strobe & ~sel;
  assign bus_a.MRW     = rw;
  assign bus_a.MAddr   = addr;
  assign bus_a.MDataIn = wdata;
  assign bus_b.MStrobe = strobe & sel;
  assign bus_b.MRW     = rw;
  assign bus_b.MAddr   = addr;
  assign bus_b.MDataIn = wdata;

  wire        ready = sel ? bus_b.MReady    : bus_a.MReady;
  wire        busy  = sel ? bus_b.Busy      : bus_a.Busy;
  wire        err   = sel ? bus_b.StrobeErr : bus_a.StrobeErr;
  wire [31:0] dout  = sel ? bus_b.MDataOut  : bus_a.MDataOut;

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  mem_responder #(.ADDR_W(8), .DATA_W(32), .WAIT_CYCLES(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle and record MReady activity seen in it.
  task automatic tick_mon(input int n);
    @(negedge clk);
    if (ready) begin
      rdy_cnt++;
      if (first_rdy == 0) first_rdy = n;
      mon_data = dout;
    end
  endtask

  // Issue one access at the current negedge; returns latency in cycles and
  // the read data seen with MReady. Leaves the bench in the IDLE cycle
  // right after MReady, where a back-to-back access may be issued.
  task automatic do_access(input logic wr, input logic [7:0] a, input logic [31:0] d,
                           output int l, output logic [31:0] r);
    strobe = 1'b1;
    rw     = wr;
    addr   = a;
    wdata  = d;
    l      = 0;
    do begin
      @(negedge clk);
      strobe = 1'b0;
      l++;
    end while (!ready && l < 20);
    r = dout;
    @(negedge clk);
    check("ready_single_pulse", {31'd0, ready}, 32'd0);
  endtask

  initial begin
    reset  = 1'b1;
    sel    = 1'b0;
    strobe = 1'b1;
    rw     = 1'b1;
    addr   = 8'h10;
    wdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy",   {31'd0, busy},  32'd0);
    check("rst_ready",  {31'd0, ready}, 32'd0);
    check("rst_dout",   dout,           32'd0);
    check("rst_err",    {31'd0, err},   32'd0);
    strobe = 1'b0;
    reset  = 1'b0;
    @(negedge clk);
    check("idle_busy", {31'd0, busy}, 32'd0);

    // Basic write then read at 0x10.
    do_access(1'b1, 8'h10, 32'hDEAD_BEEF, lat, rd);
    check("wr10_lat", lat, 32'd5);
    check("wr_keeps_dout", dout, 32'd0);
    do_access(1'b0, 8'h10, 32'h0, lat, rd);
    check("rd10_lat", lat, 32'd5);
    check("rd10_data", rd, 32'hDEAD_BEEF);

    // Address decode ends.
    do_access(1'b1, 8'h00, 32'h1111_0000, lat, rd);
    check("wr_keeps_dout2", dout, 32'hDEAD_BEEF);
    do_access(1'b1, 8'hFF, 32'h0000_FFFF, lat, rd);
    do_access(1'b0, 8'h00, 32'h0, lat, rd);
    check("rd00_data", rd, 32'h1111_0000);
    do_access(1'b0, 8'hFF, 32'h0, lat, rd);
    check("rdFF_data", rd, 32'h0000_FFFF);
    check("rdFF_lat", lat, 32'd5);

    // Stray strobe in the second WAIT cycle of a read of 0x10.
    rdy_cnt = 0; first_rdy = 0; mon_data = 32'h0;
    strobe = 1'b1; rw = 1'b0; addr = 8'h10;
    tick_mon(1);
    strobe = 1'b0; addr = 8'h00;
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("err_clear_before", {31'd0, err}, 32'd0);
    tick_mon(2);
    strobe = 1'b1;
    tick_mon(3);
    strobe = 1'b0;
    check("err_set", {31'd0, err}, 32'd1);
    for (int i = 4; i <= 12; i++) tick_mon(i);
    check("stray_ready_count", rdy_cnt, 32'd1);
    check("stray_ready_lat", first_rdy, 32'd5);
    check("stray_data", mon_data, 32'hDEAD_BEEF);
    check("err_sticky", {31'd0, err}, 32'd1);
    check("stray_idle", {31'd0, busy}, 32'd0);

    // Reset in the third WAIT cycle aborts a write to 0x20.
    do_access(1'b1, 8'h20, 32'hAAAA_5555, lat, rd);
    strobe = 1'b1; rw = 1'b1; addr = 8'h20; wdata = 32'h1234_5678;
    @(negedge clk);
    strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_ready", {31'd0, ready}, 32'd0);
    check("abort_dout",  dout,           32'd0);
    check("abort_err",   {31'd0, err},   32'd0);
    reset = 1'b0;
    rdy_cnt = 0; first_rdy = 0;
    for (int i = 1; i <= 6; i++) tick_mon(i);
    check("abort_no_ready", rdy_cnt, 32'd0);
    do_access(1'b0, 8'h20, 32'h0, lat, rd);
    check("abort_no_commit", rd, 32'hAAAA_5555);
    do_access(1'b1, 8'h20, 32'hCAFE_F00D, lat, rd);
    do_access(1'b0, 8'h20, 32'h0, lat, rd);
    check("rd20_data", rd, 32'hCAFE_F00D);

    // Inputs wiggling during WAIT must not disturb a write to 0x05.
    for (int i = 6; i <= 9; i++) do_access(1'b1, 8'(i), 32'h6000_0000 | i, lat, rd);
    strobe = 1'b1; rw = 1'b1; addr = 8'h05; wdata = 32'h0505_A5A5;
    cyc = 0;
    do begin
      @(negedge clk);
      strobe = 1'b0;
      cyc++;
      addr  = 8'(5 + cyc);
      wdata = 32'hBAD0_0000 | cyc;
    end while (!ready && cyc < 20);
    check("wiggle_lat", cyc, 32'd5);
    @(negedge clk);
    check("wiggle_keeps_dout", dout, 32'hCAFE_F00D);
    do_access(1'b0, 8'h05, 32'h0, lat, rd);
    check("rd05_data", rd, 32'h0505_A5A5);
    for (int i = 6; i <= 9; i++) begin
      do_access(1'b0, 8'(i), 32'h0, lat, rd);
      check("neighbour_intact", rd, 32'h6000_0000 | i);
    end

    // One wait state, back-to-back accesses.
    sel = 1'b1;
    @(negedge clk);
    do_access(1'b1, 8'h03, 32'h3333_3333, lat, rd);
    check("w1_wr_lat", lat, 32'd2);
    do_access(1'b0, 8'h03, 32'h0, lat, rd);
    check("w1_rd_lat", lat, 32'd2);
    check("w1_rd_data", rd, 32'h3333_3333);
    do_access(1'b0, 8'h03, 32'h0, lat, rd);
    check("w1_b2b_lat", lat, 32'd2);
    check("w1_b2b_data", rd, 32'h3333_3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
